// File: rtl/mtm_alu_serializer.sv
// Transmit side of the ALU serial link: latches one C/CTL pair and shifts it out
// on sout as MTM frames (start, type, 8 payload bits MSB first, stop).
module mtm_alu_serializer #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] C,
  input  logic [7:0]  CTL,
  output logic        ready,
  output logic        sout,
  output logic        tx_done
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CTL_W   = 8;
  localparam int unsigned BAUD_W  = 8;
  localparam int unsigned BIT_W   = 3;
  localparam int unsigned FRAME_W = 3;

  localparam logic [BAUD_W-1:0]  BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CTL_W-1:0]   CTL_IDLE    = 8'hFF;
  localparam logic [FRAME_W-1:0] FRAMES_FULL = FRAME_W'(4);
  localparam logic [BIT_W-1:0]   BIT_MSB     = BIT_W'(7);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    TYPE  = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } state_t;

  state_t              state_q;
  state_t              state_nxt;
  logic [BAUD_W-1:0]   baud_q;
  logic [BAUD_W-1:0]   baud_nxt;
  logic [BIT_W-1:0]    bit_q;
  logic [BIT_W-1:0]    bit_nxt;
  logic [FRAME_W-1:0]  frame_q;
  logic [FRAME_W-1:0]  frame_nxt;
  logic [DATA_W-1:0]   c_q;
  logic [CTL_W-1:0]    ctl_q;
  logic [CTL_W-1:0]    payload;
  logic                bit_end;
  logic                accept;
  logic                sout_nxt;
  logic                ready_nxt;
  logic                done_nxt;

  assign accept  = (state_q == IDLE) && in_valid && (CTL != CTL_IDLE);
  assign bit_end = (baud_q == BAUD_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      IDLE:  if (accept)  state_nxt = START;
      START: if (bit_end) state_nxt = TYPE;
      TYPE:  if (bit_end) state_nxt = DATA;
      DATA:  if (bit_end && (bit_q == '0)) state_nxt = STOP;
      STOP:  if (bit_end) state_nxt = (frame_q != '0) ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Baud, bit and frame counters; frame_q counts frames still to send after this one
  always_comb begin
    baud_nxt  = baud_q;
    bit_nxt   = bit_q;
    frame_nxt = frame_q;
    if ((state_q == IDLE) || bit_end) baud_nxt = '0;
    else                              baud_nxt = baud_q + 1'b1;
    if ((state_q == TYPE) && bit_end)      bit_nxt = BIT_MSB;
    else if ((state_q == DATA) && bit_end) bit_nxt = bit_q - 1'b1;
    if (accept)
      frame_nxt = CTL[7] ? '0 : FRAMES_FULL;
    else if ((state_q == STOP) && bit_end && (frame_q != '0))
      frame_nxt = frame_q - 1'b1;
  end

  // Payload byte of the frame in flight; the last frame is always CTL
  always_comb begin
    payload = ctl_q;
    unique case (frame_q)
      3'd4:    payload = c_q[31:24];
      3'd3:    payload = c_q[23:16];
      3'd2:    payload = c_q[15:8];
      3'd1:    payload = c_q[7:0];
      default: payload = ctl_q;
    endcase
  end

  // Output logic: values for the cycle after the coming edge
  always_comb begin
    sout_nxt  = 1'b1;
    ready_nxt = 1'b0;
    done_nxt  = (state_q == STOP) && (state_nxt == IDLE);
    unique case (state_nxt)
      IDLE:    ready_nxt = 1'b1;
      START:   sout_nxt  = 1'b0;
      TYPE:    sout_nxt  = (frame_q == '0);
      DATA:    sout_nxt  = payload[bit_nxt];
      STOP:    sout_nxt  = 1'b1;
      default: sout_nxt  = 1'b1;
    endcase
  end

  // Datapath and registered outputs; reset forces the line idle at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_q  <= '0;
      bit_q   <= '0;
      frame_q <= '0;
      c_q     <= '0;
      ctl_q   <= '0;
      sout    <= 1'b1;
      ready   <= 1'b1;
      tx_done <= 1'b0;
    end else begin
      baud_q  <= baud_nxt;
      bit_q   <= bit_nxt;
      frame_q <= frame_nxt;
      if (accept) begin
        c_q   <= C;
        ctl_q <= CTL;
      end
      sout    <= sout_nxt;
      ready   <= ready_nxt;
      tx_done <= done_nxt;
    end
  end

endmodule
